// File: rtl/fxp_pkg.sv
// fxp_pkg: shared fixed-point constants and helpers.
//   RND_FLOOR / RND_ZERO / RND_HALF_UP : rounding mode selectors
//   FXP_WIDTH_DEF / FXP_FRAC_DEF       : default word width and fraction bits
//   fxp_round_shift(product, frac, mode): rounds a wide signed product and
//     arithmetically shifts it right by frac. It works on a 128-bit container
//     so that any product up to 2*64 bits can be passed in sign-extended.
package fxp_pkg;

  localparam int RND_FLOOR   = 0;
  localparam int RND_ZERO    = 1;
  localparam int RND_HALF_UP = 2;

  localparam int FXP_WIDTH_DEF = 32;
  localparam int FXP_FRAC_DEF  = 10;

  localparam int FXP_PROD_MAX_W = 128;
  typedef logic signed [FXP_PROD_MAX_W-1:0] fxp_wide_t;

  function automatic fxp_wide_t fxp_round_shift(input fxp_wide_t product,
                                                input int        frac,
                                                input int        mode);
    fxp_wide_t bias;
    bias = '0;
    // With no fraction bits there is nothing to round away.
    if (frac > 0) begin
      if (mode == RND_ZERO && product[FXP_PROD_MAX_W-1])
        bias = (fxp_wide_t'(1) <<< frac) - fxp_wide_t'(1);
      else if (mode == RND_HALF_UP)
        bias = fxp_wide_t'(1) <<< (frac - 1);
    end
    return (product + bias) >>> frac;
  endfunction

endpackage

// File: rtl/fxp_sat.sv
// fxp_sat: clamps a rounded/shifted 2*WIDTH-bit value into WIDTH bits.
//   value : rounded and shifted product (two's complement, 2*WIDTH bits)
//   data  : value if it fits, otherwise the nearest WIDTH-bit bound
//   ovf   : 1 when value did not fit in WIDTH bits
module fxp_sat
  import fxp_pkg::*;
#(
  parameter int WIDTH = FXP_WIDTH_DEF
) (
  input  logic [2*WIDTH-1:0] value,
  output logic [WIDTH-1:0]   data,
  output logic               ovf
);

  logic [WIDTH:0] upper;
  assign upper = value[2*WIDTH-1:WIDTH-1];

  always_comb begin
    data = value[WIDTH-1:0];
    ovf  = 1'b0;
    // The value fits exactly when all bits above the result sign bit
    // replicate it.
    if (!((&upper) || (~|upper))) begin
      ovf  = 1'b1;
      data = value[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                              : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/fxp_mul_pipe.sv
// fxp_mul_pipe: three-stage signed fixed-point multiplier with valid/ready
// handshake and a per-sample channel tag.
//   clock, reset_n        : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     : operand handshake (in_ready is combinational)
//   in_a, in_b            : signed Q(WIDTH-FRAC).FRAC operands
//   in_tag                : channel tag, travels with its sample
//   out_valid/out_ready   : result handshake
//   out_data, out_tag     : signed product in the operand format and its tag
//   out_ovf               : saturation flag
// Build option: define FXP_MUL_SAT_EN to saturate results that do not fit in
// WIDTH bits (and raise out_ovf); otherwise results wrap and out_ovf is 0.
module fxp_mul_pipe
  import fxp_pkg::*;
#(
  parameter int WIDTH      = FXP_WIDTH_DEF,
  parameter int FRAC       = FXP_FRAC_DEF,
  parameter int ROUND_MODE = RND_FLOOR,
  parameter int TAG_W      = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_ovf
);

  typedef logic signed [2*WIDTH-1:0] prod_t;
  typedef logic signed [WIDTH-1:0]   word_t;

  function automatic prod_t round_shift(input prod_t p);
    return prod_t'(fxp_round_shift(fxp_wide_t'(p), FRAC, ROUND_MODE));
  endfunction

  logic             adv;
  word_t            a_p0, b_p0;
  logic [TAG_W-1:0] tag_p0, tag_p1, tag_p2;
  logic             vld_p0, vld_p1, vld_p2;
  prod_t            prod_p1;
  word_t            data_p2;
  logic             ovf_p2;
  word_t            res_p1;
  logic             ovf_res_p1;

  // The whole pipe moves as one; a stalled output freezes every stage.
  assign adv      = !vld_p2 || out_ready;
  assign in_ready = adv;

  // ---- S3 combinational: round, shift, then wrap or saturate ----
`ifdef FXP_MUL_SAT_EN
  prod_t rnd_p1;
  assign rnd_p1 = round_shift(prod_p1);

  fxp_sat #(.WIDTH(WIDTH)) u_sat (
    .value (rnd_p1),
    .data  (res_p1),
    .ovf   (ovf_res_p1)
  );
`else
  assign res_p1     = word_t'(round_shift(prod_p1));
  assign ovf_res_p1 = 1'b0;
`endif

  // Valid bits and the visible output registers are reset; internal data
  // registers only load alongside a valid sample.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      tag_p2  <= '0;
      ovf_p2  <= 1'b0;
    end else if (adv) begin
      vld_p0 <= in_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      // ---- S3 register: output ----
      if (vld_p1) begin
        data_p2 <= res_p1;
        tag_p2  <= tag_p1;
        ovf_p2  <= ovf_res_p1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (adv) begin
      // ---- S1 register: operands and tag ----
      if (in_valid) begin
        a_p0   <= word_t'(in_a);
        b_p0   <= word_t'(in_b);
        tag_p0 <= in_tag;
      end
      // ---- S2 register: full-width product ----
      if (vld_p0) begin
        prod_p1 <= prod_t'(a_p0) * prod_t'(b_p0);
        tag_p1  <= tag_p0;
      end
    end
  end

  assign out_valid = vld_p2;
  assign out_data  = data_p2;
  assign out_tag   = tag_p2;
  assign out_ovf   = ovf_p2;

endmodule

// File: tb/tb_fxp_mul_pipe.sv
// Bench for fxp_mul_pipe: one instance per rounding mode, all sharing the same
// stimulus and handshake, checked against an arithmetic model kept in a queue.
module tb_fxp_mul_pipe;

  localparam int WIDTH = 32;
  localparam int FRAC  = 10;
  localparam int TAG_W = 2;
  localparam int NM    = 3;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             in_valid, out_ready;
  logic [WIDTH-1:0] in_a, in_b;
  logic [TAG_W-1:0] in_tag;
  logic             in_ready  [NM];
  logic             out_valid [NM];
  logic             out_ovf   [NM];
  logic [WIDTH-1:0] out_data  [NM];
  logic [TAG_W-1:0] out_tag   [NM];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [TAG_W-1:0] tag;
  } smp_t;
  smp_t exp_q[$];

  always #5 clock = ~clock;

  for (genvar m = 0; m < NM; m++) begin : g_dut
    fxp_mul_pipe #(
      .WIDTH(WIDTH), .FRAC(FRAC), .ROUND_MODE(m), .TAG_W(TAG_W)
    ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready[m]),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_tag    (in_tag),
      .out_valid (out_valid[m]),
      .out_ready (out_ready),
      .out_data  (out_data[m]),
      .out_tag   (out_tag[m]),
      .out_ovf   (out_ovf[m])
    );
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---- reference model: exact rational arithmetic on the product ----
  function automatic longint fdiv(input longint p, input longint d);
    longint q;
    q = p / d;
    if ((p % d) != 0 && p < 0) q = q - 1;
    return q;
  endfunction

  function automatic longint scaled(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    input int mode);
    longint p, d;
    p = longint'($signed(a)) * longint'($signed(b));
    d = longint'(1) << FRAC;
    case (mode)
      0:       return fdiv(p, d);
      1:       return p / d;
      default: return fdiv(p + d / 2, d);
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] exp_data(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b, input int mode);
    longint q;
    q = scaled(a, b, mode);
`ifdef FXP_MUL_SAT_EN
    if (q > MAXV) return 32'h7FFFFFFF;
    if (q < MINV) return 32'h80000000;
`endif
    return q[WIDTH-1:0];
  endfunction

  function automatic logic exp_ovf(input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b, input int mode);
    longint q;
    q = scaled(a, b, mode);
`ifdef FXP_MUL_SAT_EN
    return (q > MAXV) || (q < MINV);
`else
    return (q > MAXV) && (q < MINV);
`endif
  endfunction

  // ---- compare process: checks outputs, tracks accepted/consumed samples ----
  always @(negedge clock) begin
    if (!reset_n) begin
      exp_q.delete();
    end else begin
      for (int m = 0; m < NM; m++)
        chk("in_ready_rule", in_ready[m], !out_valid[m] || out_ready);
      for (int m = 0; m < NM; m++) begin
        if (out_valid[m]) begin
          if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
          else begin
            chk("out_data", out_data[m], exp_data(exp_q[0].a, exp_q[0].b, m));
            chk("out_tag",  out_tag[m],  exp_q[0].tag);
            chk("out_ovf",  out_ovf[m],  exp_ovf(exp_q[0].a, exp_q[0].b, m));
          end
        end
      end
      if (out_valid[0] && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (in_valid && in_ready[0]) exp_q.push_back('{a: in_a, b: in_b, tag: in_tag});
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_valid_all(input string name, input logic v);
    for (int m = 0; m < NM; m++) chk(name, out_valid[m], v);
  endtask

  initial begin
    int got, first, last;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_a = '0; in_b = '0; in_tag = '0;
    repeat (2) step();
    for (int m = 0; m < NM; m++) begin
      chk("reset_valid", out_valid[m], 0);
      chk("reset_data",  out_data[m],  0);
      chk("reset_tag",   out_tag[m],   0);
      chk("reset_ovf",   out_ovf[m],   0);
    end
    reset_n = 1'b1;
    #1;
    chk("ready_after_reset", in_ready[0], 1);

    // Pin the model with hand-computed values.
    chk("model_1p5x2",   exp_data(32'd1536, 32'd2048, 0), 32'd3072);
    chk("model_neg_m0",  exp_data(32'hFFFFFFFF, 32'd512, 0), 32'hFFFFFFFF);
    chk("model_neg_m1",  exp_data(32'hFFFFFFFF, 32'd512, 1), 32'd0);
    chk("model_neg_m2",  exp_data(32'hFFFFFFFF, 32'd512, 2), 32'd0);

    // 1.5 * 2.0 with 3-cycle latency and a one-cycle valid pulse.
    step();
    in_valid = 1'b1; in_a = 32'd1536; in_b = 32'd2048; in_tag = 2'd1;
    step();
    in_valid = 1'b0;
    chk_valid_all("lat_c1", 0);
    step();
    chk_valid_all("lat_c2", 0);
    step();
    chk_valid_all("lat_c3", 1);
    for (int m = 0; m < NM; m++) begin
      chk("mul_1p5x2_data", out_data[m], 32'd3072);
      chk("mul_1p5x2_tag",  out_tag[m],  2'd1);
    end
    step();
    chk_valid_all("lat_c4", 0);

    // -1 LSB * 0.5 under each rounding mode.
    in_valid = 1'b1; in_a = 32'hFFFFFFFF; in_b = 32'd512; in_tag = 2'd2;
    step();
    in_valid = 1'b0;
    step(); step();
    chk("round_m0", out_data[0], 32'hFFFFFFFF);
    chk("round_m1", out_data[1], 32'd0);
    chk("round_m2", out_data[2], 32'd0);
    step();

    // Back-to-back stream of 10 samples.
    got = 0; first = -1; last = -1;
    for (int i = 0; i < 14; i++) begin
      if (i < 10) begin
        in_valid = 1'b1;
        in_a = $urandom_range(0, 8191) - 4096;
        in_b = $urandom_range(0, 8191) - 4096;
        in_tag = TAG_W'(i % 4);
      end else in_valid = 1'b0;
      step();
      if (out_valid[0]) begin
        got++;
        if (first < 0) first = i;
        last = i;
      end
    end
    chk("stream_count", got, 10);
    chk("stream_consecutive", last - first, 9);

    // Three in flight, output stalled for 4 cycles.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_a = 32'd1024 * (i + 1); in_b = 32'd3072; in_tag = TAG_W'(i + 1);
      if (i == 2) out_ready = 1'b0;
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("stall_in_ready", in_ready[0], 0);
      chk("stall_data", out_data[0], 32'd3072);
      chk_valid_all("stall_valid", 1);
      step();
    end
    out_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid[0]) got++;
      step();
    end
    chk("stall_release_count", got, 3);

    // Largest positive value times 2.0.
    in_valid = 1'b1; in_a = 32'h7FFFFFFF; in_b = 32'd2048; in_tag = 2'd3;
    step();
    in_valid = 1'b0;
    step(); step();
    for (int m = 0; m < NM; m++) begin
`ifdef FXP_MUL_SAT_EN
      chk("ovf_data", out_data[m], 32'h7FFFFFFF);
      chk("ovf_flag", out_ovf[m], 1);
`else
      chk("wrap_data", out_data[m], 32'hFFFFFFFE);
      chk("wrap_flag", out_ovf[m], 0);
`endif
    end
    step();

    // Reset pulsed mid-stall with two samples in flight.
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 32'd2048; in_b = 32'd2048; in_tag = 2'd1;
    step();
    in_a = 32'd4096; in_tag = 2'd2;
    step();
    in_valid = 1'b0;
    step();
    chk_valid_all("pre_reset_valid", 1);
    reset_n = 1'b0;
    #1;
    chk_valid_all("async_reset_valid", 0);
    for (int m = 0; m < NM; m++) chk("async_reset_data", out_data[m], 0);
    step();
    reset_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 32'hFFFFF400; in_b = 32'd1536; in_tag = 2'd2;
    step();
    in_valid = 1'b0;
    chk_valid_all("post_reset_c1", 0);
    step();
    chk_valid_all("post_reset_c2", 0);
    step();
    chk_valid_all("post_reset_c3", 1);
    for (int m = 0; m < NM; m++) begin
      chk("post_reset_data", out_data[m], 32'hFFFFEE00);
      chk("post_reset_tag",  out_tag[m],  2'd2);
    end
    step();

    // Randomised traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 1) == 0) begin
        in_a = $urandom_range(0, 65535) - 32768;
        in_b = $urandom_range(0, 65535) - 32768;
      end else begin
        in_a = $urandom;
        in_b = $urandom;
      end
      in_tag = TAG_W'($urandom);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) step();
    chk("drain_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
